mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one unified single-port instruction/data memory between the fetch stage (IF, port 0) and the load/store unit (LSU, port 1) of the RISC-V core. It accepts one transaction at a time, forwards the winner's command to the memory and routes the response back to the owning requester after a fixed memory latency. Ties are broken round-robin so neither port starves. It sits between `riscv_single_core`'s fetch/LSU request ports and the memory macro.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (port 0)
// and the load/store unit (port 1). One transaction in flight, fixed read latency.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [AW-1:0]     ls_addr,
    input  logic [DW-1:0]     ls_wdata,
    input  logic [DW/8-1:0]   ls_wstrb,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DW-1:0]     ls_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    input  logic [DW-1:0]     mem_rdata,

    output logic              busy
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    localparam logic [3:0] LatCnt = 4'(MEM_LAT);
    localparam logic       PortIf = 1'b0;
    localparam logic       PortLs = 1'b1;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;

    logic       arb_open;
    logic       grant_if;
    logic       grant_ls;
    logic       done;

    // Arbitration is only open in IDLE and never while reset is held, so a requester
    // cannot see a grant for a command the memory will never execute.
    assign arb_open = (state_q == StIdle) && rst;
    assign grant_if = arb_open && if_req && (!ls_req || (last_q == PortLs));
    assign grant_ls = arb_open && ls_req && (!if_req || (last_q == PortIf));
    assign done     = (state_q == StBusy) && (cnt_q == LatCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= PortIf;
            last_q  <= PortIf;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (grant_if || grant_ls) begin
                    state_d = StBusy;
                    owner_d = grant_ls;
                    last_d  = grant_ls;
                    cnt_d   = 4'd1;
                end
            end
            StBusy: begin
                if (done) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        if_gnt    = grant_if;
        ls_gnt    = grant_ls;
        mem_req   = grant_if || grant_ls;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (grant_ls) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_wstrb = ls_wstrb;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
        if_rvalid = done && (owner_q == PortIf);
        ls_rvalid = done && (owner_q == PortLs);
        if_rdata  = mem_rdata;
        ls_rdata  = mem_rdata;
        busy      = (state_q == StBusy);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 3) share one stimulus
// set; each phase resets them all and checks the instance whose latency it targets.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] mem_rdata;

    logic [2:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata  [3];
    logic [31:0] ls_rdata  [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wstrb [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .AW      (32),
            .DW      (32),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .ls_req    (ls_req),
            .ls_we     (ls_we),
            .ls_addr   (ls_addr),
            .ls_wdata  (ls_wdata),
            .ls_wstrb  (ls_wstrb),
            .ls_gnt    (ls_gnt[g]),
            .ls_rvalid (ls_rvalid[g]),
            .ls_rdata  (ls_rdata[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst    = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        rst    = 1'b1;
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        ls_we     = 1'b1;
        ls_addr   = 32'h0000_0200;
        ls_wdata  = 32'hDEAD_BEEF;
        ls_wstrb  = 4'hF;
        mem_rdata = 32'h0;

        // Reset held with both requests high: everything quiet.
        tick();
        tick();
        check("rst_if_gnt",    32'(if_gnt[1]),    32'd0);
        check("rst_ls_gnt",    32'(ls_gnt[1]),    32'd0);
        check("rst_mem_req",   32'(mem_req[1]),   32'd0);
        check("rst_mem_we",    32'(mem_we[1]),    32'd0);
        check("rst_mem_addr",  mem_addr[1],       32'd0);
        check("rst_mem_wdata", mem_wdata[1],      32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb[1]), 32'd0);
        check("rst_busy",      32'(busy[1]),      32'd0);
        check("rst_if_rvalid", 32'(if_rvalid[1]), 32'd0);
        check("rst_ls_rvalid", 32'(ls_rvalid[1]), 32'd0);

        // Release: first tie goes to LSU, then strict alternation every 3 cycles (MEM_LAT=2).
        rst = 1'b1;
        #1;
        check("rr_first_mem_we", 32'(mem_we[1]), 32'd1);
        for (int k = 0; k < 18; k++) begin
            check($sformatf("rr_ls_gnt_%0d", k),    32'(ls_gnt[1]),    32'((k % 6) == 0));
            check($sformatf("rr_if_gnt_%0d", k),    32'(if_gnt[1]),    32'((k % 6) == 3));
            check($sformatf("rr_ls_rvalid_%0d", k), 32'(ls_rvalid[1]), 32'((k % 6) == 2));
            check($sformatf("rr_if_rvalid_%0d", k), 32'(if_rvalid[1]), 32'((k % 6) == 5));
            if ((k % 6) == 0) check($sformatf("rr_ls_addr_%0d", k), mem_addr[1], 32'h200);
            if ((k % 6) == 3) check($sformatf("rr_if_addr_%0d", k), mem_addr[1], 32'h100);
            tick();
        end

        // Single IF read, MEM_LAT=1.
        reset_all();
        ls_we     = 1'b0;
        if_req    = 1'b1;
        mem_rdata = 32'h0050_0093;
        #1;
        check("if1_gnt",       32'(if_gnt[0]),    32'd1);
        check("if1_mem_req",   32'(mem_req[0]),   32'd1);
        check("if1_mem_addr",  mem_addr[0],       32'h100);
        check("if1_mem_we",    32'(mem_we[0]),    32'd0);
        check("if1_mem_wstrb", 32'(mem_wstrb[0]), 32'd0);
        check("if1_mem_wdata", mem_wdata[0],      32'd0);
        check("if1_busy_T",    32'(busy[0]),      32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("if1_rvalid",    32'(if_rvalid[0]), 32'd1);
        check("if1_rdata",     if_rdata[0],       32'h0050_0093);
        check("if1_busy_T1",   32'(busy[0]),      32'd1);
        check("if1_no_gnt_T1", 32'(if_gnt[0]),    32'd0);
        check("if1_ls_rvalid", 32'(ls_rvalid[0]), 32'd0);
        tick();
        check("if1_idle_busy",   32'(busy[0]),      32'd0);
        check("if1_idle_rvalid", 32'(if_rvalid[0]), 32'd0);

        // LSU write, MEM_LAT=2, then an IF request arriving in the completion cycle.
        reset_all();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h0000_0200;
        ls_wdata = 32'hDEAD_BEEF;
        ls_wstrb = 4'hF;
        #1;
        check("wr_ls_gnt",    32'(ls_gnt[1]),    32'd1);
        check("wr_if_gnt",    32'(if_gnt[1]),    32'd0);
        check("wr_mem_we",    32'(mem_we[1]),    32'd1);
        check("wr_mem_wstrb", 32'(mem_wstrb[1]), 32'hF);
        check("wr_mem_wdata", mem_wdata[1],      32'hDEAD_BEEF);
        check("wr_mem_addr",  mem_addr[1],       32'h200);
        tick();
        ls_req = 1'b0;
        #1;
        check("wr_rvalid_T1", 32'(ls_rvalid[1]), 32'd0);
        check("wr_busy_T1",   32'(busy[1]),      32'd1);
        tick();
        check("wr_rvalid_T2",    32'(ls_rvalid[1]), 32'd1);
        check("wr_if_rvalid_T2", 32'(if_rvalid[1]), 32'd0);
        if_req = 1'b1;
        #1;
        check("late_no_gnt", 32'(if_gnt[1]),  32'd0);
        check("late_no_req", 32'(mem_req[1]), 32'd0);
        tick();
        check("late_gnt",      32'(if_gnt[1]),  32'd1);
        check("late_mem_addr", mem_addr[1],     32'h100);
        check("late_mem_we",   32'(mem_we[1]),  32'd0);
        check("late_busy",     32'(busy[1]),    32'd0);
        tick();
        if_req = 1'b0;

        // MEM_LAT=3: reset at T+2 abandons the read; a fresh read then completes at T+3.
        reset_all();
        ls_req    = 1'b0;
        if_req    = 1'b1;
        mem_rdata = 32'h0;
        #1;
        check("ab_gnt", 32'(if_gnt[2]), 32'd1);
        tick();
        if_req = 1'b0;
        tick();
        check("ab_busy_T2", 32'(busy[2]), 32'd1);
        rst = 1'b0;
        #1;
        check("ab_busy_rst",   32'(busy[2]),      32'd0);
        check("ab_rvalid_rst", 32'(if_rvalid[2]), 32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("ab_quiet_%0d", k), 32'(if_rvalid[2]), 32'd0);
        end
        if_req    = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check("re_gnt", 32'(if_gnt[2]), 32'd1);
        tick();
        if_req = 1'b0;
        #1;
        check("re_rvalid_T1", 32'(if_rvalid[2]), 32'd0);
        tick();
        check("re_rvalid_T2", 32'(if_rvalid[2]), 32'd0);
        tick();
        check("re_rvalid_T3", 32'(if_rvalid[2]), 32'd1);
        check("re_rdata_T3",  if_rdata[2],       32'h1234_5678);
        check("re_busy_T3",   32'(busy[2]),      32'd1);
        tick();
        check("re_rvalid_T4", 32'(if_rvalid[2]), 32'd0);
        check("re_busy_T4",   32'(busy[2]),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
